varredura_tabuleiro: RTL and testbench
======================================

VARREDURA_TABULEIRO -- requirements
Module: varredura_tabuleiro

Interface
REQ-001 Parameter SETTLE, default 4, cycles each row is driven before its columns are sampled (range 2..15).
REQ-002 Parameter DEBOUNCE, default 3, consecutive identical full scans required to accept a square (range 1..7).
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 habilita  in  1  1 = scanning enabled; 0 = scan halted.
REQ-006 colunas_n  in  8  board column sense lines, active-low (pulled up; 0 = square occupied/pressed on driven row).
REQ-007 linhas_n  out  8  board row drive, one-hot active-low.
REQ-008 jogadaLinha  out  4  accepted square row, 0..7, bit 3 always 0.
REQ-009 jogadaColuna  out  4  accepted square column, 0..7, bit 3 always 0.
REQ-010 jogou  out  1  level, high from acceptance of a square until the board reads empty.
REQ-011 multiplo  out  1  high for one full scan period after a scan that found 2 or more active squares.
REQ-012 db_estado  out  3  current FSM state code, for debug.

Function
REQ-013 FSM states SHALL be: PARADO, DIRIGE, AMOSTRA, AVALIA.
REQ-014 PARADO: linhas_n = 8'hFF; row index = 0; go to DIRIGE when habilita = 1.
REQ-015 DIRIGE: linhas_n drives the current row low for SETTLE-1 cycles, then go to AMOSTRA.
REQ-016 AMOSTRA: one cycle with the same row still driven; capture ~colunas_n into the scan image for that row; row < 7 -> row+1, DIRIGE; row = 7 -> AVALIA.
REQ-017 Each row is therefore driven for exactly SETTLE cycles; AVALIA lasts one cycle with linhas_n = 8'hFF; full scan period = 8*SETTLE+1 cycles (33 at default).
REQ-018 AVALIA, zero active squares: clear candidate and stable count; deassert jogou.
REQ-019 AVALIA, exactly one active square equal to the candidate: stable count +1, saturating at DEBOUNCE.
REQ-020 AVALIA, exactly one active square that differs from the candidate (or no candidate): load it as candidate; stable count = 1.
REQ-021 When the stable count reaches DEBOUNCE and jogou = 0: load jogadaLinha/jogadaColuna from the candidate and set jogou = 1 on that same edge. jogadaLinha/jogadaColuna SHALL change only at acceptance.
REQ-022 While jogou = 1, a different single square SHALL NOT be accepted; a new acceptance requires an intervening empty scan.
REQ-023 AVALIA, two or more active squares: clear candidate and count; jogou unchanged; multiplo = 1 until the next AVALIA.
REQ-024 After AVALIA: if habilita = 1, return to DIRIGE with row 0; otherwise go to PARADO.
REQ-025 habilita -> 0 mid-scan: finish the current row's AMOSTRA, then go to PARADO; the partial scan image is discarded. Candidate, count, jogou and coordinates are kept.
REQ-026 Counting active squares: saturating 2-bit count (0, 1, 2+). Row and column are encoded in binary, 3 bits each, zero-extended to 4.

Reset
REQ-027 While reset = 0: state = PARADO, linhas_n = 8'hFF, jogadaLinha = 0, jogadaColuna = 0, jogou = 0, multiplo = 0, db_estado = 0, candidate cleared, stable count = 0, settle counter = 0, scan image cleared.
REQ-028 Reset is released synchronously: its deassertion is synchronised to clock through two flops before it is used internally.

Structure
REQ-029 A shared package SHALL hold the state encodings (PARADO = 0, DIRIGE = 1, AMOSTRA = 2, AVALIA = 3) and the board size constant 8.
REQ-030 The settle timer SHALL be a separate sub-module, contador_m, instanced with M = SETTLE, fim output, and cleared on row change.

Verification
REQ-031 Reset, then habilita = 1 with colunas_n = 8'hFF: linhas_n walks FE, FD, ... 7F, 4 cycles each, then FF for 1 cycle; period = 33 cycles; jogou stays 0.
REQ-032 Square (row 2, col 5) held active for 3 scans: at the 3rd AVALIA, jogou -> 1 with jogadaLinha = 2 and jogadaColuna = 5; jogou stays 1 while the square is held; jogou -> 0 at the first empty AVALIA.
REQ-033 Square (row 2, col 5) active for 2 scans, then (row 2, col 6) for 3 scans: acceptance happens only at the 5th AVALIA, with coordinates (2, 6).
REQ-034 Squares (1, 1) and (4, 7) active together: multiplo = 1 for 33 cycles after that AVALIA; jogou and coordinates unchanged.
REQ-035 habilita -> 0 during the row-4 drive: scanning stops after row 4's AMOSTRA and linhas_n = FF; with habilita -> 1 the scan restarts at row 0 (FE).
REQ-036 reset asserted during DIRIGE with jogou = 1: all outputs take their reset values immediately, with no clock edge.

Source files
------------

// File: rtl/varredura_tabuleiro_pkg.sv
// Shared definitions for the board scanner: FSM state codes, board size and
// small helpers used to evaluate a captured scan image.
package varredura_tabuleiro_pkg;

    localparam int TAM = 8;

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        DIRIGE  = 2'd1,
        AMOSTRA = 2'd2,
        AVALIA  = 2'd3
    } estado_t;

    // Saturating add of two 0/1/2+ counts (2 means "two or more").
    function automatic logic [1:0] soma_sat(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // Number of active squares on one row, saturated at 2.
    function automatic logic [1:0] conta_linha(input logic [TAM-1:0] v);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < TAM; i++) begin
            if (v[i]) c = soma_sat(c, 2'd1);
        end
        return c;
    endfunction

    // Binary index of the lowest active column (only meaningful with one bit set).
    function automatic logic [2:0] codifica(input logic [TAM-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = TAM - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/varredura_tabuleiro_contador_m.sv
// Settle timer: counts the drive cycles of one row. o_fim marks the last
// drive cycle, so drive plus the following sample cycle spans M cycles.
module contador_m #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_limpa,
    input  logic i_conta,
    output logic o_fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] r_conta;

    // Count up while enabled, restart from zero whenever the row changes.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_conta <= '0;
        end else if (i_limpa) begin
            r_conta <= '0;
        end else if (i_conta) begin
            r_conta <= (r_conta == W'(M - 1)) ? '0 : r_conta + W'(1);
        end
    end

    assign o_fim = (r_conta == W'(M - 2));

endmodule

// File: rtl/varredura_tabuleiro.sv
// 8x8 board scanner: drives one row at a time, samples the column lines,
// and after each full scan debounces a single occupied square into a move.
module varredura_tabuleiro
    import varredura_tabuleiro_pkg::*;
#(
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           habilita,
    input  logic [TAM-1:0] colunas_n,
    output logic [TAM-1:0] linhas_n,
    output logic [3:0]     jogadaLinha,
    output logic [3:0]     jogadaColuna,
    output logic           jogou,
    output logic           multiplo,
    output logic [2:0]     db_estado
);

    logic [1:0]     r_sync;
    logic           w_rst_n;
    estado_t        r_estado;
    estado_t        w_estado_next;
    logic [2:0]     r_linha;
    logic [TAM-1:0] r_imagem [TAM];
    logic           w_fim;
    logic           w_limpa;
    logic           w_conta;

    logic [1:0]     w_qtd_linha [TAM];
    logic [2:0]     w_col_linha [TAM];
    logic [1:0]     w_qtd;
    logic [2:0]     w_pos_lin;
    logic [2:0]     w_pos_col;

    logic           r_cand_valido;
    logic [2:0]     r_cand_lin;
    logic [2:0]     r_cand_col;
    logic [2:0]     r_estavel;
    logic [2:0]     w_estavel_novo;
    logic           w_aceita;
    logic           r_jogou;
    logic           r_multiplo;
    logic [2:0]     r_jog_lin;
    logic [2:0]     r_jog_col;

    // Reset asserts immediately but is released only after two clock edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], 1'b1};
    end

    assign w_rst_n = r_sync[1];

    assign w_limpa = (r_estado != DIRIGE);
    assign w_conta = (r_estado == DIRIGE);

    contador_m #(.M(SETTLE)) u_settle (
        .clock   (clock),
        .rst_n   (w_rst_n),
        .i_limpa (w_limpa),
        .i_conta (w_conta),
        .o_fim   (w_fim)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) r_estado <= PARADO;
        else          r_estado <= w_estado_next;
    end

    // Next state and row drive; a completed row 7 is always evaluated.
    always_comb begin
        w_estado_next = r_estado;
        linhas_n      = '1;
        case (r_estado)
            PARADO: begin
                if (habilita) w_estado_next = DIRIGE;
            end
            DIRIGE: begin
                linhas_n = ~(TAM'(1) << r_linha);
                if (w_fim) w_estado_next = AMOSTRA;
            end
            AMOSTRA: begin
                linhas_n = ~(TAM'(1) << r_linha);
                if (r_linha == 3'd7) w_estado_next = AVALIA;
                else if (habilita)   w_estado_next = DIRIGE;
                else                 w_estado_next = PARADO;
            end
            AVALIA: begin
                w_estado_next = habilita ? DIRIGE : PARADO;
            end
            default: w_estado_next = PARADO;
        endcase
    end

    // Row pointer: advance after each sample, restart at row 0 otherwise.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_linha <= 3'd0;
        end else if (r_estado == AMOSTRA) begin
            r_linha <= (w_estado_next == DIRIGE) ? r_linha + 3'd1 : 3'd0;
        end else if (r_estado != DIRIGE) begin
            r_linha <= 3'd0;
        end
    end

    // Scan image: capture the active columns of the sampled row; a halted
    // scan throws its partial image away.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < TAM; i++) r_imagem[i] <= '0;
        end else if (r_estado == PARADO) begin
            for (int i = 0; i < TAM; i++) r_imagem[i] <= '0;
        end else if (r_estado == AMOSTRA) begin
            r_imagem[r_linha] <= ~colunas_n;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TAM; gi++) begin : g_linha
            assign w_qtd_linha[gi] = conta_linha(r_imagem[gi]);
            assign w_col_linha[gi] = codifica(r_imagem[gi]);
        end
    endgenerate

    // Whole-board count (0, 1, 2+) and position of the active square.
    always_comb begin
        w_qtd     = 2'd0;
        w_pos_lin = 3'd0;
        w_pos_col = 3'd0;
        for (int i = 0; i < TAM; i++) begin
            if (w_qtd_linha[i] != 2'd0) begin
                w_qtd     = soma_sat(w_qtd, w_qtd_linha[i]);
                w_pos_lin = 3'(i);
                w_pos_col = w_col_linha[i];
            end
        end
    end

    // Debounce step: grow the stable count on a repeat, restart on a new square.
    always_comb begin
        w_estavel_novo = 3'd1;
        if (r_cand_valido && (r_cand_lin == w_pos_lin) && (r_cand_col == w_pos_col)) begin
            w_estavel_novo = (r_estavel >= 3'(DEBOUNCE)) ? 3'(DEBOUNCE) : r_estavel + 3'd1;
        end
        w_aceita = (r_estado == AVALIA) && (w_qtd == 2'd1) &&
                   (w_estavel_novo == 3'(DEBOUNCE)) && !r_jogou;
    end

    // Per-scan decision: candidate tracking, move acceptance and flags.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cand_valido <= 1'b0;
            r_cand_lin    <= 3'd0;
            r_cand_col    <= 3'd0;
            r_estavel     <= 3'd0;
            r_jogou       <= 1'b0;
            r_multiplo    <= 1'b0;
            r_jog_lin     <= 3'd0;
            r_jog_col     <= 3'd0;
        end else if (r_estado == AVALIA) begin
            case (w_qtd)
                2'd0: begin
                    r_cand_valido <= 1'b0;
                    r_cand_lin    <= 3'd0;
                    r_cand_col    <= 3'd0;
                    r_estavel     <= 3'd0;
                    r_jogou       <= 1'b0;
                    r_multiplo    <= 1'b0;
                end
                2'd1: begin
                    r_cand_valido <= 1'b1;
                    r_cand_lin    <= w_pos_lin;
                    r_cand_col    <= w_pos_col;
                    r_estavel     <= w_estavel_novo;
                    r_multiplo    <= 1'b0;
                    if (w_aceita) begin
                        r_jogou   <= 1'b1;
                        r_jog_lin <= w_pos_lin;
                        r_jog_col <= w_pos_col;
                    end
                end
                default: begin
                    r_cand_valido <= 1'b0;
                    r_cand_lin    <= 3'd0;
                    r_cand_col    <= 3'd0;
                    r_estavel     <= 3'd0;
                    r_multiplo    <= 1'b1;
                end
            endcase
        end
    end

    assign jogadaLinha  = {1'b0, r_jog_lin};
    assign jogadaColuna = {1'b0, r_jog_col};
    assign jogou        = r_jogou;
    assign multiplo     = r_multiplo;
    assign db_estado    = {1'b0, r_estado};

endmodule

// File: tb/tb_varredura_tabuleiro.sv
// Bench for varredura_tabuleiro: a board model answers the row drive, a
// table of per-scan vectors checks debounce/acceptance, and hand sequences
// cover the multi-square period, halting mid-scan and asynchronous reset.
module tb_varredura_tabuleiro;

    localparam int SETTLE   = 4;
    localparam int DEBOUNCE = 3;
    localparam int PERIODO  = 8 * SETTLE + 1;
    localparam int NV       = 21;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [7:0] colunas_n;
    logic [7:0] linhas_n;
    logic [3:0] jogadaLinha;
    logic [3:0] jogadaColuna;
    logic       jogou;
    logic       multiplo;
    logic [2:0] db_estado;

    logic [7:0][7:0] tabuleiro;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a_val; int a_lin; int a_col;
        int b_val; int b_lin; int b_col;
        int e_jogou; int e_lin; int e_col; int e_mult;
    } vetor_t;

    vetor_t tabela [NV];

    always #5 clock = ~clock;

    varredura_tabuleiro #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (
        .clock        (clock),
        .reset        (reset),
        .habilita     (habilita),
        .colunas_n    (colunas_n),
        .linhas_n     (linhas_n),
        .jogadaLinha  (jogadaLinha),
        .jogadaColuna (jogadaColuna),
        .jogou        (jogou),
        .multiplo     (multiplo),
        .db_estado    (db_estado)
    );

    // Board model: an occupied square pulls its column low while its row is driven.
    always_comb begin
        colunas_n = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            if (!linhas_n[r]) colunas_n = colunas_n & ~tabuleiro[r];
        end
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic poe(input int av, input int al, input int ac,
                       input int bv, input int bl, input int bc);
        tabuleiro = '0;
        if (av != 0) tabuleiro[al][ac] = 1'b1;
        if (bv != 0) tabuleiro[bl][bc] = 1'b1;
    endtask

    task automatic espera_avalia();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (db_estado != 3'd3 && n < 3 * PERIODO);
        check("espera_avalia", 32'(db_estado), 32'd3);
    endtask

    initial begin
        logic [7:0] esp;
        int n;

        //                  a_val lin col  b_val lin col  jogou lin col mult
        tabela[0]  = '{1, 2, 5,  0, 0, 0,  0, 0, 0, 0};
        tabela[1]  = '{1, 2, 5,  0, 0, 0,  0, 0, 0, 0};
        tabela[2]  = '{1, 2, 5,  0, 0, 0,  1, 2, 5, 0};
        tabela[3]  = '{1, 2, 5,  0, 0, 0,  1, 2, 5, 0};
        tabela[4]  = '{0, 0, 0,  0, 0, 0,  0, 2, 5, 0};
        tabela[5]  = '{1, 2, 5,  0, 0, 0,  0, 2, 5, 0};
        tabela[6]  = '{1, 2, 5,  0, 0, 0,  0, 2, 5, 0};
        tabela[7]  = '{1, 2, 6,  0, 0, 0,  0, 2, 5, 0};
        tabela[8]  = '{1, 2, 6,  0, 0, 0,  0, 2, 5, 0};
        tabela[9]  = '{1, 2, 6,  0, 0, 0,  1, 2, 6, 0};
        tabela[10] = '{1, 1, 1,  1, 4, 7,  1, 2, 6, 1};
        tabela[11] = '{1, 3, 3,  0, 0, 0,  1, 2, 6, 0};
        tabela[12] = '{1, 3, 3,  0, 0, 0,  1, 2, 6, 0};
        tabela[13] = '{1, 3, 3,  0, 0, 0,  1, 2, 6, 0};
        tabela[14] = '{1, 3, 3,  0, 0, 0,  1, 2, 6, 0};
        tabela[15] = '{0, 0, 0,  0, 0, 0,  0, 2, 6, 0};
        tabela[16] = '{1, 7, 0,  0, 0, 0,  0, 2, 6, 0};
        tabela[17] = '{1, 7, 0,  0, 0, 0,  0, 2, 6, 0};
        tabela[18] = '{1, 7, 0,  0, 0, 0,  1, 7, 0, 0};
        tabela[19] = '{1, 5, 2,  1, 5, 3,  1, 7, 0, 1};
        tabela[20] = '{0, 0, 0,  0, 0, 0,  0, 7, 0, 0};

        tabuleiro = '0;
        habilita  = 1'b0;
        reset     = 1'b1;
        #1 reset  = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_linhas", 32'(linhas_n), 32'hFF);
        check("rst_jogou", 32'(jogou), 32'd0);
        check("rst_lin", 32'(jogadaLinha), 32'd0);
        check("rst_col", 32'(jogadaColuna), 32'd0);
        check("rst_mult", 32'(multiplo), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);

        // Empty board walk: each row low for SETTLE cycles, then one idle cycle
        reset    = 1'b1;
        habilita = 1'b1;
        n = 0;
        while (linhas_n != 8'hFE && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("inicio_fe", 32'(linhas_n), 32'hFE);
        for (int i = 0; i < PERIODO; i++) begin
            esp = 8'hFF;
            if (i < 8 * SETTLE) esp[i / SETTLE] = 1'b0;
            check("varredura", 32'(linhas_n), 32'(esp));
            @(negedge clock);
        end
        check("periodo_fe", 32'(linhas_n), 32'hFE);
        check("vazio_jogou", 32'(jogou), 32'd0);
        $display("walk: period %0d cycles checked", PERIODO);

        // Per-scan vectors; aligned at the first drive cycle of a scan
        for (int v = 0; v < NV; v++) begin
            poe(tabela[v].a_val, tabela[v].a_lin, tabela[v].a_col,
                tabela[v].b_val, tabela[v].b_lin, tabela[v].b_col);
            espera_avalia();
            @(negedge clock);
            check("tab_jogou", 32'(jogou), 32'(tabela[v].e_jogou));
            check("tab_lin", 32'(jogadaLinha), 32'(tabela[v].e_lin));
            check("tab_col", 32'(jogadaColuna), 32'(tabela[v].e_col));
            check("tab_mult", 32'(multiplo), 32'(tabela[v].e_mult));
            $display("scan %0d: jogou=%0b lin=%0d col=%0d mult=%0b",
                     v, jogou, jogadaLinha, jogadaColuna, multiplo);
        end

        // Accept (6,4), then a two-square scan must leave the move untouched
        for (int k = 0; k < DEBOUNCE; k++) begin
            poe(1, 6, 4, 0, 0, 0);
            espera_avalia();
            @(negedge clock);
        end
        check("aceita_jogou", 32'(jogou), 32'd1);
        check("aceita_lin", 32'(jogadaLinha), 32'd6);
        check("aceita_col", 32'(jogadaColuna), 32'd4);
        $display("accept: jogou=%0b lin=%0d col=%0d", jogou, jogadaLinha, jogadaColuna);

        poe(1, 1, 1, 1, 4, 7);
        espera_avalia();
        @(negedge clock);
        check("multi_jogou", 32'(jogou), 32'd1);
        check("multi_lin", 32'(jogadaLinha), 32'd6);
        check("multi_col", 32'(jogadaColuna), 32'd4);
        poe(0, 0, 0, 0, 0, 0);
        n = 0;
        while (multiplo && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("multi_ciclos", 32'(n), 32'(PERIODO));
        $display("multiplo: high for %0d cycles", n);

        // Re-accept (6,4) so the halt sequence runs with jogou set
        for (int k = 0; k < DEBOUNCE; k++) begin
            poe(1, 6, 4, 0, 0, 0);
            espera_avalia();
            @(negedge clock);
        end
        check("reaceita_jogou", 32'(jogou), 32'd1);

        // Halt during row 4 drive: finish row 4, then idle with all rows high
        repeat (4 * SETTLE + 1) @(negedge clock);
        habilita = 1'b0;
        check("parada_l4_a", 32'(linhas_n), 32'hEF);
        @(negedge clock);
        check("parada_l4_b", 32'(linhas_n), 32'hEF);
        @(negedge clock);
        check("parada_amostra", 32'(db_estado), 32'd2);
        @(negedge clock);
        check("parada_ff", 32'(linhas_n), 32'hFF);
        check("parada_estado", 32'(db_estado), 32'd0);
        repeat (5) @(negedge clock);
        check("parada_fica", 32'(linhas_n), 32'hFF);
        check("parada_jogou", 32'(jogou), 32'd1);
        check("parada_lin", 32'(jogadaLinha), 32'd6);
        check("parada_col", 32'(jogadaColuna), 32'd4);
        habilita = 1'b1;
        @(negedge clock);
        check("retoma_fe", 32'(linhas_n), 32'hFE);
        check("retoma_estado", 32'(db_estado), 32'd1);
        $display("halt/resume: linhas_n=%0h estado=%0d jogou=%0b", linhas_n, db_estado, jogou);

        // Asynchronous reset while driving with a move held
        reset = 1'b0;
        #1;
        check("arst_linhas", 32'(linhas_n), 32'hFF);
        check("arst_jogou", 32'(jogou), 32'd0);
        check("arst_lin", 32'(jogadaLinha), 32'd0);
        check("arst_col", 32'(jogadaColuna), 32'd0);
        check("arst_mult", 32'(multiplo), 32'd0);
        check("arst_estado", 32'(db_estado), 32'd0);
        $display("async reset: linhas_n=%0h jogou=%0b estado=%0d", linhas_n, jogou, db_estado);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
